// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB first, one stop bit checked.
// Define UART_RX_SYNC_EN to put a two-flop synchronizer in front of the line sample.
module uart_rx #(
    parameter int c_clkfreq  = 100_000_000,
    parameter int c_baudrate = 10_000_000,
    parameter int c_databits = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_i,
    output logic [c_databits-1:0] dout_o,
    output logic                  rx_done_tick_o,
    output logic                  frame_err_o
);

    localparam int N  = c_clkfreq / c_baudrate;
    localparam int H  = N / 2;
    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(c_databits + 1);
    localparam int DB = c_databits;

    localparam logic [TW-1:0] T_FULL = TW'(N - 1);
    localparam logic [TW-1:0] T_HALF = TW'(H - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DB - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DB-1:0]   shreg_q, shreg_d;
    logic [DB-1:0]   dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            rs_q, rs_d;
    logic [DB:0]     shift_in;

`ifdef UART_RX_SYNC_EN
    logic [1:0]      sync_q, sync_d;

    // two-flop synchronizer ahead of the line sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_d = {sync_q[0], rx_i};
    assign rs_d   = sync_q[1];
`else
    assign rs_d   = rx_i;
`endif

    assign shift_in = {rs_q, shreg_q};

    // next-state and output decode, all decisions on the registered sample
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                cnt_d   = '0;
                if (!rs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    state_d = rs_q ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    shreg_d = shift_in[DB:1];
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        state_d = S_STOP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    if (rs_q) begin
                        dout_d  = shreg_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_BREAK: begin
                timer_d = '0;
                cnt_d   = '0;
                if (rs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                timer_d = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // receiver state, line sample and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            rs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            rs_q    <= rs_d;
        end
    end

    assign dout_o         = dout_q;
    assign rx_done_tick_o = done_q;
    assign frame_err_o    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a queue-based receive model.
// Expected pulse times come from the bit-period arithmetic of the line protocol.
module tb_uart_rx;

    localparam int N  = 10;
    localparam int H  = N / 2;
    localparam int DB = 10;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = H + (DB + 1) * N + 2 + SYNC;

    logic          clk;
    logic          rst_n;
    logic          rx_i;
    logic [DB-1:0] dout_o;
    logic          rx_done_tick_o;
    logic          frame_err_o;

    uart_rx #(
        .c_clkfreq (100_000_000),
        .c_baudrate(10_000_000),
        .c_databits(DB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_i          (rx_i),
        .dout_o        (dout_o),
        .rx_done_tick_o(rx_done_tick_o),
        .frame_err_o   (frame_err_o)
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    int both  = 0;

    logic [DB-1:0] got_w[$];
    int            got_t[$];
    int            err_t[$];
    logic [DB-1:0] exp_w[$];
    int            exp_t[$];
    logic [DB-1:0] last_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter: number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // record every output pulse with its cycle stamp
    always @(negedge clk) begin
        if (rx_done_tick_o) begin
            got_w.push_back(dout_o);
            got_t.push_back(cyc);
        end
        if (frame_err_o) err_t.push_back(cyc);
        if (rx_done_tick_o && frame_err_o) both <= both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one frame; abort_bit >= 0 stops halfway through that data bit
    task automatic send_frame(input logic [DB-1:0] w, input logic stop_lvl,
                              input int nstop, input int abort_bit,
                              output int e0);
        @(negedge clk);
        e0 = cyc;
        rx_i = 1'b0;
        repeat (N) @(negedge clk);
        for (int k = 0; k < DB; k++) begin
            rx_i = w[k];
            if (k == abort_bit) begin
                repeat (H) @(negedge clk);
                return;
            end
            repeat (N) @(negedge clk);
        end
        rx_i = stop_lvl;
        repeat (nstop * N) @(negedge clk);
    endtask

    task automatic good_frame(input logic [DB-1:0] w, input int nstop);
        int e0;
        send_frame(w, 1'b1, nstop, -1, e0);
        exp_w.push_back(w);
        exp_t.push_back(e0 + LAT);
        last_word = w;
    endtask

    // compare recorded done pulses with the expected queue, then clear both
    task automatic check_frames(input string tag);
        int n;
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_word%0d", tag, i), got_w[i], exp_w[i]);
            chk($sformatf("%s_time%0d", tag, i), got_t[i], exp_t[i]);
        end
        chk({tag, "_dout"}, dout_o, last_word);
        chk({tag, "_noerr"}, err_t.size(), 0);
        got_w.delete();
        got_t.delete();
        exp_w.delete();
        exp_t.delete();
        err_t.delete();
    endtask

    initial begin
        int e0;
        int len;
        logic [DB-1:0] w;

        rx_i  = 1'b1;
        rst_n = 1'b1;
        last_word = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dout", dout_o, 0);
        chk("reset_done", rx_done_tick_o, 0);
        chk("reset_ferr", frame_err_o, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        good_frame(10'h2A5, 1);
        check_frames("single");

        good_frame(10'h3FF, 2);
        good_frame(10'h000, 2);
        good_frame(10'h155, 2);
        check_frames("b2b");

        for (int g = 1; g <= 4; g++) begin
            @(negedge clk);
            rx_i = 1'b0;
            repeat (g) @(negedge clk);
            rx_i = 1'b1;
            repeat (20) @(negedge clk);
        end
        check_frames("glitch");

        send_frame(10'h0F0, 1'b0, 1, -1, e0);
        repeat (50) @(negedge clk);
        rx_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("ferr_count", err_t.size(), 1);
        if (err_t.size() > 0) chk("ferr_time", err_t[0], e0 + LAT);
        chk("ferr_nodone", got_w.size(), 0);
        chk("ferr_dout", dout_o, last_word);
        err_t.delete();
        good_frame(10'h0C5, 1);
        check_frames("after_err");

        send_frame(10'h3A7, 1'b1, 1, 4, e0);
        rst_n = 1'b0;
        #1;
        chk("rst_dout", dout_o, 0);
        chk("rst_done", rx_done_tick_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        rx_i = 1'b1;
        last_word = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_frames("rst_mid");
        good_frame(10'h1C3, 1);
        check_frames("after_rst");

        for (int i = 0; i < 10; i++) begin
            w = DB'($urandom_range(0, (1 << DB) - 1));
            len = $urandom_range(1, 2);
            good_frame(w, len);
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end
        check_frames("random");

        chk("never_both", both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter c_clkfreq, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter c_baudrate, default 10_000_000, meaning line bit rate in baud.
REQ-003 SHALL have parameter c_databits, default 10, meaning data bits per frame, LSB first.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_i, input, 1 bit: serial line, idle high.
REQ-007 SHALL have port dout_o, output, c_databits bits: last correctly framed word.
REQ-008 SHALL have port rx_done_tick_o, output, 1 bit: one-cycle pulse when dout_o is updated.
REQ-009 SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when the stop bit samples low.

Function
REQ-010 SHALL define N = c_clkfreq/c_baudrate and H = N/2 (integer division); N >= 4 is required of the integrator.
REQ-011 SHALL size the bit timer to ceil(log2(N)) bits and the bit counter to ceil(log2(c_databits+1)) bits.
REQ-012 SHALL treat "rs" as the registered line sample; every decision uses rs, never raw rx_i.
REQ-013 SHALL implement states IDLE, START, DATA, STOP and BREAK.
REQ-014 IDLE: timer and counter held at 0; rs==0 -> START.
REQ-015 START: count to H-1; at H-1, rs==0 -> DATA, with timer cleared.
REQ-016 START: at H-1, rs==1 -> IDLE (glitch reject); no output pulses.
REQ-017 DATA: at each timer==N-1, shift rs into the MSB of the shift register (right shift) and increment the counter.
REQ-018 DATA: after the c_databits-th sample -> STOP, with timer cleared.
REQ-019 STOP: at timer==N-1, rs==1 -> dout_o <= shift register, rx_done_tick_o=1 for one cycle, -> IDLE.
REQ-020 STOP: at timer==N-1, rs==0 -> frame_err_o=1 for one cycle, dout_o unchanged, -> BREAK.
REQ-021 BREAK: remain until rs==1, then -> IDLE; a held-low line yields exactly one frame_err_o pulse.
REQ-022 Timing: with the start edge first seen in IDLE at cycle t0, bit k (0-based) SHALL be sampled at t0+H+(k+1)*N and the stop bit at t0+H+(c_databits+1)*N.
REQ-023 The done or error pulse SHALL be visible in the cycle after the stop-bit sample.
REQ-024 Only one stop bit is checked; extra stop bits are consumed in IDLE, so back-to-back frames from uart_tx with c_stopbit >= 1 are received without loss.
REQ-025 rx_done_tick_o and frame_err_o SHALL never be high in the same cycle.
REQ-026 Unused state encodings SHALL return to IDLE on the next clock.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, timer 0, counter 0, shift register 0, dout_o 0, rx_done_tick_o 0, frame_err_o 0, synchronizer flops 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial word with no pulse; after release, reception resumes at the next falling edge.

Configuration
REQ-029 Macro UART_RX_SYNC_EN defined: rx_i SHALL pass through a two-flop synchronizer before rs, adding 2 cycles to all REQ-022/023 times.
REQ-030 Macro UART_RX_SYNC_EN undefined: rs SHALL be a single register on rx_i, with no added latency.

Verification (N=10, H=5, c_databits=10, macro undefined)
REQ-031 Send frame 0x2A5 with 1 stop bit -> one rx_done_tick_o pulse at t0+H+11N+1, dout_o==0x2A5, frame_err_o never high.
REQ-032 Three back-to-back frames 0x3FF, 0x000, 0x155 with 2 stop bits each -> three done pulses, values in order.
REQ-033 4-cycle low glitch on an idle line -> returns to IDLE at t0+5, no pulses, dout_o unchanged.
REQ-034 Frame 0x0F0 with stop bit low, then line held low 50 cycles, then high -> exactly one frame_err_o pulse, dout_o unchanged, next valid frame received.
REQ-035 rst_n pulsed low during data bit 4 -> all outputs 0 immediately, no pulse, following frame 0x1C3 received correctly.
REQ-036 With UART_RX_SYNC_EN defined, repeat REQ-031 -> same data, done pulse 2 cycles later.
